bit_serializer: RTL and testbench
=================================

# bit_serializer

- Upstream feeder for the serial sequence recognizer.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the single-bit `X` line the recognizer samples.
- Optionally inserts idle gap cycles between words and an even-parity bit per word.
- Sits between the test/stimulus side of the design and the recognizer's `X` input.

## Interface

Parameters:
- `WIDTH`, default 8: word width in bits; legal range 2..16.
- `GAP`, default 0: idle cycles inserted after each frame; legal range 0..15.
- `IDLE_BIT`, default 0: level driven on `X` when no data bit is being sent.

Ports:
- `CK` in 1: the single clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `DIN` in WIDTH: parallel word to send.
- `DIN_VALID` in 1: `DIN` holds a word to send.
- `DIN_READY` out 1: block accepts `DIN` at this edge; combinational from state.
- `X` out 1: serial data bit, registered.
- `X_VALID` out 1: `X` carries a frame bit this cycle, registered.
- `LAST` out 1: current `X` is the final bit of the frame, registered.
- `BUSY` out 1: state is not IDLE.

## Operation

- States:
  - IDLE: waiting for a word.
  - SHIFT: data bits being sent.
  - PARITY: parity bit being sent; exists only with the macro defined.
  - GAP: idle cycles between frames.
- Accept occurs on a rising edge when `DIN_VALID && DIN_READY`. On accept:
  - `DIN` is captured into the shift register.
  - `X` is loaded with `DIN[WIDTH-1]` and `X_VALID` is set to 1.
  - The bit counter is loaded with `WIDTH-1`.
  - State moves to SHIFT.
- SHIFT: each edge shifts the next lower bit onto `X`. After bit 0 is driven:
  - go to PARITY if parity is enabled;
  - otherwise go to GAP if `GAP>0`;
  - otherwise go to IDLE, or back to SHIFT if a new accept happens on that edge.
- PARITY: drives one cycle of even parity on `X`, equal to the XOR of all WIDTH bits, with `X_VALID=1`. Then go to GAP or IDLE, using the same rule as SHIFT.
- GAP: drives `X=IDLE_BIT` and `X_VALID=0` for exactly `GAP` cycles, then go to IDLE.
- `LAST` is 1 exactly in the cycle `X` holds the final frame bit: bit 0, or the parity bit when enabled.
- `DIN_READY` = (state==IDLE) || (`LAST` && `GAP==0`). This allows gap-free back-to-back frames.
- `DIN` and `DIN_VALID` are ignored whenever `DIN_READY` is 0. Holding `DIN` stable is the sender's duty.
- Whenever no frame bit is being driven (IDLE or GAP): `X=IDLE_BIT`, `X_VALID=0`, `LAST=0`.
- Reset values: `X=IDLE_BIT`, `X_VALID=0`, `LAST=0`, `BUSY=0`, state IDLE, so `DIN_READY=1`.
- Reset asserted mid-frame aborts the frame immediately, with no resume. The first edge after `RESET` deasserts may accept a new word.

## Timing

- Latency: the MSB appears on `X` in the cycle after the accept edge.
- Frame length on `X`: WIDTH cycles, or WIDTH+1 with parity.
- Throughput with `GAP=0` and `DIN_VALID` held high: one bit every cycle with no bubble.
- Throughput with `GAP>0`: one frame every WIDTH(+1)+GAP+1 cycles, including the IDLE accept cycle.
- `BUSY` is high from the cycle after accept until the last GAP cycle (or the final frame bit when `GAP=0`).

## Configuration

- Macro `BIT_SERIALIZER_PARITY_EN`:
  - Defined: PARITY state is compiled in, and every frame gets one trailing even-parity bit carrying `LAST`.
  - Undefined: PARITY state and the XOR logic are absent, frames are exactly WIDTH bits, and `LAST` is on bit 0.

## Test plan

- Reset, then idle: `X=0`, `X_VALID=0`, `DIN_READY=1`. Assert `RESET=0` mid-frame: all outputs return to reset values within the same cycle, asynchronously.
- WIDTH=8, no parity, GAP=0: send 0xA5. `X` = 1,0,1,0,0,1,0,1 on cycles 1–8 after the accept; `LAST` is high only on cycle 8; `X_VALID` drops on cycle 9.
- GAP=0, `DIN_VALID` held: send 0xFF then 0x00. 16 contiguous `X_VALID` cycles showing eight 1s then eight 0s; the second accept occurs on the edge where `LAST=1`.
- GAP=2: send 0x81 twice back-to-back. Between the frames: 2 cycles with `X_VALID=0` and `X=IDLE_BIT`, plus 1 IDLE accept cycle; `DIN_READY=0` during SHIFT and GAP.
- Parity macro defined: 0xA5 gives a 9th bit of 0; 0x07 gives a 9th bit of 1; `LAST` is on the 9th bit.
- Connect to the recognizer: stream 0x60 (0,1,1,0,0,…). The recognizer's `Z` responds exactly as it does for the same bit sequence driven directly on its `X`.

Source files
------------

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - parallel word in / serial bit out signal bundle
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             X;
  logic             X_VALID;
  logic             LAST;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, X, X_VALID, LAST
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, X, X_VALID, LAST
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first word serializer with optional idle gap
// Optional trailing even-parity bit is compiled in by BIT_SERIALIZER_PARITY_EN.
module bit_serializer #(
  parameter int WIDTH    = 8,
  parameter int GAP      = 0,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic            CK,
  input  logic            RESET,
  bit_serializer_if.slave s,
  output logic            BUSY
);
  localparam int CW = $clog2(WIDTH);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAPS} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             accept;

  // Ready on the final frame bit lets a new word follow with no bubble.
  assign s.DIN_READY = (state == IDLE) || (s.LAST && (GAP == 0));
  assign accept      = s.DIN_VALID && s.DIN_READY;
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      s.X       <= IDLE_BIT;
      s.X_VALID <= 1'b0;
      s.LAST    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= sreg << 1;
            s.X  <= sreg[WIDTH-2];
            cnt  <= cnt - 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            s.LAST <= 1'b0;
`else
            s.LAST <= (cnt == CW'(1));
`endif
          end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state     <= PARITY;
            s.X       <= par;
            s.X_VALID <= 1'b1;
            s.LAST    <= 1'b1;
`else
            if (GAP > 0) begin
              state <= GAPS;
              gcnt  <= 4'(GAP - 1);
            end else begin
              state <= IDLE;
            end
            s.X       <= IDLE_BIT;
            s.X_VALID <= 1'b0;
            s.LAST    <= 1'b0;
`endif
          end
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        PARITY: begin
          if (GAP > 0) begin
            state <= GAPS;
            gcnt  <= 4'(GAP - 1);
          end else begin
            state <= IDLE;
          end
          s.X       <= IDLE_BIT;
          s.X_VALID <= 1'b0;
          s.LAST    <= 1'b0;
        end
`endif
        GAPS: begin
          if (gcnt == '0) state <= IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: ;
      endcase

      // Accept overrides the end-of-frame return to IDLE for back-to-back words.
      if (accept) begin
        sreg      <= s.DIN;
        s.X       <= s.DIN[WIDTH-1];
        s.X_VALID <= 1'b1;
        s.LAST    <= 1'b0;
        cnt       <= CW'(WIDTH - 1);
        state     <= SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
        par       <= ^s.DIN;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench: queue model plus directed literal checks
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy2;
  int vectors = 0;
  int misc = 0;

  always #5 ck = ~ck;

  bit_serializer_if #(.WIDTH(8)) b0 ();
  bit_serializer_if #(.WIDTH(8)) b2 ();

  bit_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) u0 (
    .CK(ck), .RESET(rst_n), .s(b0.slave), .BUSY(busy0)
  );
  bit_serializer #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0)) u2 (
    .CK(ck), .RESET(rst_n), .s(b2.slave), .BUSY(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each entry is one future output cycle {busy, valid, last, x}; 0 means IDLE.
  logic [3:0] q0[$];
  logic [3:0] q2[$];
  logic [3:0] cur0, cur2;

  function automatic bit mrdy(input logic [3:0] cur, input int gap);
    return (cur[3] == 1'b0) || (cur[1] && gap == 0);
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q2.delete();
      cur0 = 4'h0;
      cur2 = 4'h0;
    end else begin
      if (b0.DIN_VALID && mrdy(cur0, 0)) begin
        for (int b = 7; b >= 0; b--) q0.push_back({1'b1, 1'b1, (b == 0) && !PAR, b0.DIN[b]});
        if (PAR) q0.push_back({3'b111, ^b0.DIN});
      end
      if (b2.DIN_VALID && mrdy(cur2, 2)) begin
        for (int b = 7; b >= 0; b--) q2.push_back({1'b1, 1'b1, (b == 0) && !PAR, b2.DIN[b]});
        if (PAR) q2.push_back({3'b111, ^b2.DIN});
        for (int g = 0; g < 2; g++) q2.push_back(4'b1000);
      end
      cur0 = (q0.size() > 0) ? q0.pop_front() : 4'h0;
      cur2 = (q2.size() > 0) ? q2.pop_front() : 4'h0;
    end
  end

  always @(negedge ck) begin
    chk("g0_x",     {31'b0, b0.X},         {31'b0, cur0[0]});
    chk("g0_valid", {31'b0, b0.X_VALID},   {31'b0, cur0[2]});
    chk("g0_last",  {31'b0, b0.LAST},      {31'b0, cur0[1]});
    chk("g0_busy",  {31'b0, busy0},        {31'b0, cur0[3]});
    chk("g0_ready", {31'b0, b0.DIN_READY}, {31'b0, mrdy(cur0, 0)});
    chk("g2_x",     {31'b0, b2.X},         {31'b0, cur2[0]});
    chk("g2_valid", {31'b0, b2.X_VALID},   {31'b0, cur2[2]});
    chk("g2_last",  {31'b0, b2.LAST},      {31'b0, cur2[1]});
    chk("g2_busy",  {31'b0, busy2},        {31'b0, cur2[3]});
    chk("g2_ready", {31'b0, b2.DIN_READY}, {31'b0, mrdy(cur2, 2)});
  end

  logic [7:0]  cap, lcap;
  logic [15:0] cap16;
  int          vcount;
  logic [18:0] vpat, rpat;
  logic [7:0]  words [4];

  initial begin
    words[0] = 8'h3C; words[1] = 8'h07; words[2] = 8'h60; words[3] = 8'hD2;
    b0.DIN = 8'h00; b0.DIN_VALID = 1'b0;
    b2.DIN = 8'h00; b2.DIN_VALID = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_x", {31'b0, b0.X}, 32'd0);
    chk("rst_valid", {31'b0, b0.X_VALID}, 32'd0);
    chk("rst_ready", {31'b0, b0.DIN_READY}, 32'd1);
    rst_n = 1'b1;
    @(negedge ck);
    chk("idle_ready", {31'b0, b0.DIN_READY}, 32'd1);

    // 0xA5 single frame
    b0.DIN = 8'hA5; b0.DIN_VALID = 1'b1;
    @(negedge ck);
    b0.DIN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap  = {cap[6:0], b0.X};
      lcap = {lcap[6:0], b0.LAST};
      @(negedge ck);
    end
    chk("a5_bits", {24'b0, cap}, 32'hA5);
`ifdef BIT_SERIALIZER_PARITY_EN
    chk("a5_last", {24'b0, lcap}, 32'h00);
    chk("a5_par", {31'b0, b0.X}, 32'd0);
    chk("a5_par_last", {31'b0, b0.LAST}, 32'd1);
    @(negedge ck);
    b0.DIN = 8'h07; b0.DIN_VALID = 1'b1;
    @(negedge ck);
    b0.DIN_VALID = 1'b0;
    repeat (8) @(negedge ck);
    chk("07_par", {31'b0, b0.X}, 32'd1);
    chk("07_par_last", {31'b0, b0.LAST}, 32'd1);
    @(negedge ck);
`else
    chk("a5_last", {24'b0, lcap}, 32'h01);
    chk("a5_drop", {31'b0, b0.X_VALID}, 32'd0);

    // 0xFF then 0x00 with DIN_VALID held: 16 contiguous bits
    b0.DIN = 8'hFF; b0.DIN_VALID = 1'b1;
    @(negedge ck);
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) b0.DIN = 8'h00;
      if (i == 8) b0.DIN_VALID = 1'b0;
      cap16 = {cap16[14:0], b0.X};
      if (b0.X_VALID) vcount++;
      @(negedge ck);
    end
    chk("b2b_bits", {16'b0, cap16}, 32'hFF00);
    chk("b2b_valid", vcount, 32'd16);

    // GAP=2: 0x81 twice, valid held
    b2.DIN = 8'h81; b2.DIN_VALID = 1'b1;
    @(negedge ck);
    for (int i = 0; i < 19; i++) begin
      if (i == 11) b2.DIN_VALID = 1'b0;
      vpat = {vpat[17:0], b2.X_VALID};
      rpat = {rpat[17:0], b2.DIN_READY};
      @(negedge ck);
    end
    chk("gap_valid", {13'b0, vpat}, {13'b0, 19'b1111_1111_000_1111_1111});
    chk("gap_ready", {13'b0, rpat}, {13'b0, 19'b0000_0000_001_0000_0000});
`endif

    // Mixed words and valid toggling on both instances, checked by the model
    for (int i = 0; i < 60; i++) begin
      b0.DIN = words[i % 4];
      b0.DIN_VALID = ((i % 7) != 3);
      b2.DIN = words[(i + 2) % 4];
      b2.DIN_VALID = ((i % 5) != 1);
      @(negedge ck);
    end
    b0.DIN_VALID = 1'b0;
    b2.DIN_VALID = 1'b0;
    repeat (14) @(negedge ck);

    // Mid-frame asynchronous reset, then accept on the first edge after release
    b0.DIN = 8'hC3; b0.DIN_VALID = 1'b1;
    @(negedge ck);
    b0.DIN_VALID = 1'b0;
    repeat (2) @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, b0.X_VALID}, 32'd0);
    chk("arst_x", {31'b0, b0.X}, 32'd0);
    chk("arst_last", {31'b0, b0.LAST}, 32'd0);
    chk("arst_busy", {31'b0, busy0}, 32'd0);
    chk("arst_ready", {31'b0, b0.DIN_READY}, 32'd1);
    @(negedge ck);
    rst_n = 1'b1;
    b0.DIN_VALID = 1'b1;
    @(negedge ck);
    b0.DIN_VALID = 1'b0;
    chk("post_rst_valid", {31'b0, b0.X_VALID}, 32'd1);
    chk("post_rst_msb", {31'b0, b0.X}, 32'd1);
    repeat (12) @(negedge ck);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
